// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions for the bus sequencer: step states,
// opcodes, bus-source indices and instruction-register field positions.
package cpu_ctrl_pkg;

  localparam int BUS_W    = 24;
  localparam int NUM_REGS = 16;
  localparam int OPC_W    = 5;
  localparam int IR_W     = 32;

  // Instruction-register field positions.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_e;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;

  // Bus-source select bit indices; R0..R15 occupy 0..15.
  localparam logic [4:0] R0_IDX     = 5'd0;
  localparam logic [4:0] HI_IDX     = 5'd16;
  localparam logic [4:0] LO_IDX     = 5'd17;
  localparam logic [4:0] ZHI_IDX    = 5'd18;
  localparam logic [4:0] ZLO_IDX    = 5'd19;
  localparam logic [4:0] PC_IDX     = 5'd20;
  localparam logic [4:0] MDR_IDX    = 5'd21;
  localparam logic [4:0] INPORT_IDX = 5'd22;
  localparam logic [4:0] C_IDX      = 5'd23;

  // One-hot bus-source select for a given bit index.
  function automatic logic [BUS_W-1:0] bus_one_hot(input logic [4:0] idx);
    return 24'd1 << idx;
  endfunction

  // Single-result register-register ALU operations.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

  // Operations producing a HI/LO result pair.
  function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// Handshake and control bundle between the bus sequencer (master side)
// and the instruction register / memory / datapath (slave side).
interface bus_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic                start;
  logic [IR_W-1:0]     ir;
  logic                mem_rdy;
  logic [BUS_W-1:0]    bus_sel;
  logic [NUM_REGS-1:0] reg_in;
  logic                pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic                inc_pc, mem_read;
  logic [OPC_W-1:0]    alu_op;
  logic                busy, done, illegal, mem_err;

  modport master (
    input  start, ir, mem_rdy,
    output bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
           hi_in, lo_in, inc_pc, mem_read, alu_op, busy, done, illegal, mem_err
  );

  modport slave (
    output start, ir, mem_rdy,
    input  bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
           hi_in, lo_in, inc_pc, mem_read, alu_op, busy, done, illegal, mem_err
  );

endinterface

// File: rtl/bus_sequencer_mem_wait_timer.sv
// Saturating wait counter for the memory-read step. expired flags the
// enabled cycle that is the MAX_COUNT-th consecutive wait cycle.
module mem_wait_timer #(
  parameter int MAX_COUNT = 15,
  parameter int WIDTH     = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  // Count enabled cycles, holding at MAX_COUNT; clr restarts from zero.
  always_ff @(posedge clock or negedge clear_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!clear_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != WIDTH'(MAX_COUNT))) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count   = count_q;
  assign expired = en && (count_q == WIDTH'(MAX_COUNT - 1));

endmodule

// File: rtl/bus_sequencer.sv
// Control-step sequencer for the shared 32-bit datapath bus: steps fetch and
// register-register ALU instructions through T0..T6, driving one bus source
// select per cycle plus load enables, memory read and ALU opcode.
// Build option: define BUS_SEQUENCER_MULDIV_EN to enable the mul/div LO/HI
// write-back path; otherwise mul and div are reported as illegal.
module bus_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4
) (
  input  logic           clock,
  input  logic           clear_n,
  bus_sequencer_if.master bus
);

`ifdef BUS_SEQUENCER_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_q;
  logic [3:0]       ra_q, rc_q;
  logic [OPC_W-1:0] ir_op;
  logic [3:0]       ir_ra, ir_rb, ir_rc;
  logic             op_legal;
  logic [WAIT_W-1:0] wait_cnt;
  logic             wait_expired;

  assign ir_op    = bus.ir[OPC_MSB:OPC_LSB];
  assign ir_ra    = bus.ir[RA_MSB:RA_LSB];
  assign ir_rb    = bus.ir[RB_MSB:RB_LSB];
  assign ir_rc    = bus.ir[RC_MSB:RC_LSB];
  assign op_legal = is_alu_op(ir_op) || (MULDIV_EN && is_muldiv(ir_op));

  mem_wait_timer #(
    .MAX_COUNT(MEM_WAIT_MAX),
    .WIDTH    (WAIT_W)
  ) u_mem_wait_timer (
    .clock  (clock),
    .clear_n(clear_n),
    .clr    (state_q != T1),
    .en     ((state_q == T1) && !bus.mem_rdy),
    .count  (wait_cnt),
    .expired(wait_expired)
  );

  // Step register; reset abandons any instruction in flight.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Capture opcode and destination/second-source fields as T3 ends.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      op_q <= '0;
      ra_q <= '0;
      rc_q <= '0;
    end else if (state_q == T3) begin
      op_q <= ir_op;
      ra_q <= ir_ra;
      rc_q <= ir_rc;
    end
  end

  // Next step and per-step control outputs.
  always_comb begin
    // NOTE: every output and state_d gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    bus.bus_sel  = '0;
    bus.reg_in   = '0;
    bus.pc_in    = 1'b0;
    bus.ir_in    = 1'b0;
    bus.mar_in   = 1'b0;
    bus.mdr_in   = 1'b0;
    bus.y_in     = 1'b0;
    bus.z_in     = 1'b0;
    bus.hi_in    = 1'b0;
    bus.lo_in    = 1'b0;
    bus.inc_pc   = 1'b0;
    bus.mem_read = 1'b0;
    bus.alu_op   = '0;
    bus.busy     = (state_q != IDLE);
    bus.done     = 1'b0;
    bus.illegal  = 1'b0;
    bus.mem_err  = 1'b0;

    case (state_q)
      IDLE: if (bus.start) state_d = T0;
      T0: begin
        bus.bus_sel = bus_one_hot(PC_IDX);
        bus.mar_in  = 1'b1;
        bus.inc_pc  = 1'b1;
        bus.z_in    = 1'b1;
        state_d     = T1;
      end
      T1: begin
        bus.bus_sel  = bus_one_hot(ZLO_IDX);
        bus.mem_read = 1'b1;
        bus.pc_in    = (wait_cnt == '0);
        if (bus.mem_rdy) begin
          bus.mdr_in = 1'b1;
          state_d    = T2;
        end else if (wait_expired) begin
          bus.mem_err = 1'b1;
          state_d     = IDLE;
        end
      end
      T2: begin
        bus.bus_sel = bus_one_hot(MDR_IDX);
        bus.ir_in   = 1'b1;
        state_d     = T3;
      end
      T3: begin
        if (op_legal) begin
          bus.bus_sel = bus_one_hot({1'b0, ir_rb});
          bus.y_in    = 1'b1;
          state_d     = T4;
        end else begin
          bus.illegal = 1'b1;
          state_d     = IDLE;
        end
      end
      T4: begin
        bus.bus_sel = bus_one_hot({1'b0, rc_q});
        bus.alu_op  = op_q;
        bus.z_in    = 1'b1;
        state_d     = T5;
      end
      T5: begin
        bus.bus_sel = bus_one_hot(ZLO_IDX);
        if (MULDIV_EN && is_muldiv(op_q)) begin
          bus.lo_in = 1'b1;
          state_d   = T6;
        end else begin
          bus.reg_in = 16'd1 << ra_q;
          bus.done   = 1'b1;
          state_d    = IDLE;
        end
      end
      T6: begin
        bus.bus_sel = bus_one_hot(ZHI_IDX);
        bus.hi_in   = MULDIV_EN;
        bus.done    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer. Expectations follow the
// BUS_SEQUENCER_MULDIV_EN build option where mul/div behaviour differs.
module tb_bus_sequencer;
  import cpu_ctrl_pkg::*;

  localparam logic [31:0] IR_ADD  = 32'h18918000;  // add R1,R2,R3
  localparam logic [31:0] IR_R0   = 32'h18000000;  // add R0,R0,R0
  localparam logic [31:0] IR_MUL  = 32'h78228000;  // mul R4,R5
  localparam logic [31:0] IR_SHL  = 32'h58000000;  // last legal ALU opcode
  localparam logic [31:0] IR_0C   = 32'h60000000;  // 01100: unsupported
  localparam logic [31:0] IR_02   = 32'h10000000;  // 00010: unsupported
  localparam logic [31:0] IR_DIV  = 32'h80000000;  // div
  localparam int          NEVER   = 1000;

  typedef struct packed {
    logic [15:0] reg_in;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read;
    logic [4:0] alu_op;
    logic busy, done, illegal, mem_err;
  } ctrl_t;

  typedef struct {
    int done_cyc, err_cyc, ill_cyc;
    int n_read, n_mdr, n_pcin, n_irin, n_done, n_err;
    bit fin;
  } run_t;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  bus_sequencer_if sq();

  bus_sequencer #(
    .MEM_WAIT_MAX(15),
    .WAIT_W      (4)
  ) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .bus    (sq.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t obs_ctrl();
    ctrl_t c;
    c.reg_in = sq.reg_in;   c.pc_in  = sq.pc_in;  c.ir_in  = sq.ir_in;
    c.mar_in = sq.mar_in;   c.mdr_in = sq.mdr_in; c.y_in   = sq.y_in;
    c.z_in   = sq.z_in;     c.hi_in  = sq.hi_in;  c.lo_in  = sq.lo_in;
    c.inc_pc = sq.inc_pc;   c.mem_read = sq.mem_read;
    c.alu_op = sq.alu_op;   c.busy   = sq.busy;   c.done   = sq.done;
    c.illegal = sq.illegal; c.mem_err = sq.mem_err;
    return c;
  endfunction

  task automatic expect_step(input string tag, input logic [23:0] bus_exp, input ctrl_t c_exp);
    #1;
    check({tag, " bus_sel"}, 64'(sq.bus_sel), 64'(bus_exp));
    check({tag, " ctrl"}, 64'(obs_ctrl()), 64'(c_exp));
  endtask

  task automatic idle_step(input string tag, input logic start_v);
    @(negedge clock);
    sq.start = start_v;
    expect_step(tag, '0, '0);
  endtask

  // Start an instruction with memory ready immediately; check idle..T2.
  task automatic fetch_steps(input string tag, input logic [31:0] ir_v);
    ctrl_t e;
    @(negedge clock); sq.start = 1'b1; sq.ir = ir_v; sq.mem_rdy = 1'b1;
    expect_step({tag, " idle"}, '0, '0);
    @(negedge clock); sq.start = 1'b0;
    e = '0; e.busy = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    expect_step({tag, " T0"}, 24'h100000, e);
    @(negedge clock);
    e = '0; e.busy = 1; e.pc_in = 1; e.mem_read = 1; e.mdr_in = 1;
    expect_step({tag, " T1"}, 24'h080000, e);
    @(negedge clock);
    e = '0; e.busy = 1; e.ir_in = 1;
    expect_step({tag, " T2"}, 24'h200000, e);
  endtask

  // Register-register execute steps T3..T5.
  task automatic alu_steps(input string tag, input logic [23:0] rb_bus, input logic [23:0] rc_bus,
                           input logic [4:0] op, input logic [15:0] reg_exp);
    ctrl_t e;
    @(negedge clock);
    e = '0; e.busy = 1; e.y_in = 1;
    expect_step({tag, " T3"}, rb_bus, e);
    @(negedge clock);
    e = '0; e.busy = 1; e.z_in = 1; e.alu_op = op;
    expect_step({tag, " T4"}, rc_bus, e);
    @(negedge clock);
    e = '0; e.busy = 1; e.reg_in = reg_exp; e.done = 1;
    expect_step({tag, " T5"}, 24'h080000, e);
  endtask

  // Run one instruction with a memory model that answers after rdy_after
  // read cycles; records in which cycle (start accept = 0) each pulse falls.
  task automatic run_count(input string tag, input logic [31:0] ir_v, input int rdy_after,
                           output run_t r);
    int reads = 0;
    r = '{done_cyc: -1, err_cyc: -1, ill_cyc: -1, default: 0};
    @(negedge clock); sq.start = 1'b1; sq.ir = ir_v; sq.mem_rdy = 1'b0;
    for (int c = 1; c <= 60 && !r.fin; c++) begin
      @(negedge clock); sq.start = 1'b0;
      #1;
      if (sq.mem_read) reads++;
      sq.mem_rdy = sq.mem_read && (reads > rdy_after);
      #1;
      if (!sq.busy) begin
        r.fin = 1'b1;
      end else begin
        if (sq.mem_read) r.n_read++;
        if (sq.mdr_in)   r.n_mdr++;
        if (sq.pc_in)    r.n_pcin++;
        if (sq.ir_in)    r.n_irin++;
        if (sq.done)    begin r.n_done++; r.done_cyc = c; end
        if (sq.mem_err) begin r.n_err++;  r.err_cyc  = c; end
        if (sq.illegal) r.ill_cyc = c;
      end
    end
    check({tag, " finished"}, 64'(r.fin), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ctrl_t e;
    run_t  r;

    // Reset held with start asserted: everything quiet.
    sq.start = 1'b1; sq.ir = '0; sq.mem_rdy = 1'b0; clear_n = 1'b0;
    repeat (3) @(negedge clock);
    expect_step("reset hold", '0, '0);
    @(negedge clock); clear_n = 1'b1; sq.start = 1'b0;
    expect_step("reset release", '0, '0);
    idle_step("idle no start", 1'b0);

    // add R1,R2,R3, zero memory wait.
    fetch_steps("add", IR_ADD);
    alu_steps("add", 24'h000004, 24'h000008, 5'b00011, 16'h0002);

    // Back-to-back start right after done, then start while busy, then
    // reset during T4.
    idle_step("add after done", 1'b1);
    @(negedge clock); sq.start = 1'b0;
    e = '0; e.busy = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    expect_step("b2b T0", 24'h100000, e);
    @(negedge clock);
    e = '0; e.busy = 1; e.pc_in = 1; e.mem_read = 1; e.mdr_in = 1;
    expect_step("b2b T1", 24'h080000, e);
    @(negedge clock); sq.start = 1'b1;
    e = '0; e.busy = 1; e.ir_in = 1;
    expect_step("b2b T2", 24'h200000, e);
    @(negedge clock); sq.start = 1'b0;
    e = '0; e.busy = 1; e.y_in = 1;
    expect_step("busy start ignored T3", 24'h000004, e);
    @(negedge clock);
    e = '0; e.busy = 1; e.z_in = 1; e.alu_op = 5'b00011;
    expect_step("b2b T4", 24'h000008, e);
    clear_n = 1'b0;
    expect_step("reset in T4", '0, '0);
    @(negedge clock); clear_n = 1'b1;
    expect_step("after reset", '0, '0);
    idle_step("after reset idle", 1'b0);

    // All-zero register fields select R0 explicitly.
    fetch_steps("r0", IR_R0);
    alu_steps("r0", 24'h000001, 24'h000001, 5'b00011, 16'h0001);
    idle_step("r0 end", 1'b0);

    // mul R4,R5.
    fetch_steps("mul", IR_MUL);
`ifdef BUS_SEQUENCER_MULDIV_EN
    @(negedge clock);
    e = '0; e.busy = 1; e.y_in = 1;
    expect_step("mul T3", 24'h000010, e);
    @(negedge clock);
    e = '0; e.busy = 1; e.z_in = 1; e.alu_op = 5'b01111;
    expect_step("mul T4", 24'h000020, e);
    @(negedge clock);
    e = '0; e.busy = 1; e.lo_in = 1;
    expect_step("mul T5", 24'h080000, e);
    @(negedge clock);
    e = '0; e.busy = 1; e.hi_in = 1; e.done = 1;
    expect_step("mul T6", 24'h040000, e);
`else
    @(negedge clock);
    e = '0; e.busy = 1; e.illegal = 1;
    expect_step("mul illegal T3", '0, e);
`endif
    idle_step("mul end", 1'b0);

    // Latency and pulse counts.
    run_count("add nowait", IR_ADD, 0, r);
    check("add nowait done cycle", 64'(r.done_cyc), 64'(6));
    run_count("add wait3", IR_ADD, 3, r);
    check("wait3 done cycle", 64'(r.done_cyc), 64'(9));
    check("wait3 mem_read cycles", 64'(r.n_read), 64'(4));
    check("wait3 mdr_in count", 64'(r.n_mdr), 64'(1));
    check("wait3 pc_in count", 64'(r.n_pcin), 64'(1));
    run_count("timeout", IR_ADD, NEVER, r);
    check("timeout mem_err cycle", 64'(r.err_cyc), 64'(16));
    check("timeout mem_err count", 64'(r.n_err), 64'(1));
    check("timeout mem_read cycles", 64'(r.n_read), 64'(15));
    check("timeout ir_in count", 64'(r.n_irin), 64'(0));
    check("timeout done count", 64'(r.n_done), 64'(0));
    run_count("shl", IR_SHL, 0, r);
    check("shl done cycle", 64'(r.done_cyc), 64'(6));
    check("shl illegal cycle", 64'(r.ill_cyc), 64'(-1));
    run_count("op 01100", IR_0C, 0, r);
    check("op 01100 illegal cycle", 64'(r.ill_cyc), 64'(4));
    check("op 01100 done count", 64'(r.n_done), 64'(0));
    run_count("op 00010", IR_02, 0, r);
    check("op 00010 illegal cycle", 64'(r.ill_cyc), 64'(4));
    run_count("div", IR_DIV, 0, r);
`ifdef BUS_SEQUENCER_MULDIV_EN
    check("div done cycle", 64'(r.done_cyc), 64'(7));
`else
    check("div illegal cycle", 64'(r.ill_cyc), 64'(4));
    check("div done count", 64'(r.n_done), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Control-step sequencer for the shared 32-bit datapath bus.
- Walks fetch and register-register ALU instructions through timing steps T0..T6.
- Each cycle it drives exactly one one-hot bus-source select into the bus multiplexer, plus the register load enables, memory read and ALU opcode.
- Sits between the instruction register / memory interface and the datapath. It is the only driver of bus source selects.

Parameters:
- MEM_WAIT_MAX, 15: maximum number of T1 cycles spent waiting for mem_rdy before aborting.
- WAIT_W, 4: width of the memory-wait counter; must satisfy 2^WAIT_W > MEM_WAIT_MAX.

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- start  in  1  begin one instruction; sampled only in IDLE
- ir  in  32  instruction register contents; opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]
- mem_rdy  in  1  memory read data valid
- bus_sel  out  24  one-hot bus source select. Bits 0-15 = R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C
- reg_in  out  16  one-hot general register load
- pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in  out  1 each  register load enables
- inc_pc  out  1  ALU computes PC+1 this cycle
- mem_read  out  1  memory read request
- alu_op  out  5  opcode presented to ALU; 0 outside T4
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse in final step
- illegal  out  1  one-cycle pulse on an unsupported opcode
- mem_err  out  1  one-cycle pulse on memory-wait timeout

Behaviour:
- Reset: clear_n low forces state IDLE immediately (asynchronous), clears the wait counter and latched fields, and drives every output to 0. Reset mid-instruction abandons it; no partial-cycle outputs appear.
- All outputs are decoded from the registered state and the latched fields. bus_sel is all-zero in IDLE, and at most one bit is ever set.
- IDLE: start=1 moves to T0 next cycle. start is ignored while busy.
- T0: bus_sel[20] (PC), mar_in, inc_pc, z_in.
- T1: bus_sel[19] (ZLO), pc_in, mem_read.
  - pc_in is asserted only in the first T1 cycle.
  - The machine holds in T1 while mem_rdy=0, incrementing the wait counter.
  - mdr_in is asserted in the single cycle where mem_rdy=1, and the next state is T2.
  - If the counter reaches MEM_WAIT_MAX with mem_rdy still 0: mem_err pulses in that cycle and the next state is IDLE.
  - If mem_rdy=1 arrives in the same cycle as the limit, mem_rdy wins.
- T2: bus_sel[21] (MDR), ir_in.
- T3: the ir input is valid here. opcode, ra and rb are decoded live; opcode, ra and rc are latched at the end of T3.
  - Supported opcodes: 00011 through 01011 (add, sub, and, or, ror, rol, shr, shra, shl), plus 01111 (mul) and 10000 (div).
  - Supported opcode: bus_sel[rb], y_in.
  - Any other opcode: illegal pulses, no other outputs, next state is IDLE.
- T4: bus_sel[rc], alu_op=opcode, z_in.
- T5:
  - Register-register ops: bus_sel[19] (ZLO), reg_in[ra], done; next state is IDLE.
  - mul/div: bus_sel[19] (ZLO), lo_in; next state is T6.
- T6 (mul/div only): bus_sel[18] (ZHI), hi_in, done; next state is IDLE.
- Latency with zero memory wait: start accepted to done = 6 cycles (7 for mul/div). Each mem_rdy wait cycle adds 1.
- ra, rb and rc all equal to 0 is legal: R0 is selected explicitly.
- The next start is accepted in the cycle after done.

Optional Feature:
- Macro: BUS_SEQUENCER_MULDIV_EN.
- Defined: mul/div follow the T5 (LO) / T6 (HI) path described above.
- Undefined: opcodes 01111 and 10000 are illegal (illegal pulse in T3, return to IDLE). The T6 state, hi_in and lo_in are tied to 0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state enum (IDLE, T0..T6);
  - the 5-bit opcode constants;
  - the 24-bit bus-select bit-index constants (R0_IDX=0 .. C_IDX=23);
  - the IR field bit positions.
- One sub-module: mem_wait_timer. It is the saturating WAIT_W counter with clear, enable and an expired flag, instantiated for T1.

Test Plan:
- Reset: hold clear_n=0 while start=1 -> all outputs 0, busy=0. Release -> still IDLE until start is asserted.
- add R1,R2,R3 (ir=32'h18918000), mem_rdy=1 -> bus_sel per cycle:
  - T0: 0x100000
  - T1: 0x080000, with mdr_in
  - T2: 0x200000
  - T3: 0x000004, with y_in
  - T4: 0x000008, with alu_op=5'b00011
  - T5: 0x080000, with reg_in=0x0002 and done
  - busy falls in the next cycle.
- mem_rdy delayed 3 cycles -> T1 lasts 4 cycles, mdr_in high exactly once, pc_in high once, done at cycle 9.
- mem_rdy held 0 -> mem_err pulse after 15 T1 cycles, then IDLE. No ir_in or done is ever asserted.
- mul R4,R5 (ir=32'h78228000):
  - With the macro: T5 bus_sel=0x080000 with lo_in; T6 bus_sel=0x040000 with hi_in and done.
  - Without the macro: illegal pulses in T3, then IDLE.
- clear_n pulsed low during T4 -> outputs 0 in the same cycle, state IDLE. A start pulse issued while busy (before the reset) has no effect.
